// File: rtl/computie_bus_capture_ctrl.sv
// computie_bus_capture_ctrl: filters snooped Computie bus records into the capture FIFO, runs the
// pre-trigger ring and post-trigger count, then hands the FIFO read port to the serial dumper.
`default_nettype none

module computie_bus_capture_ctrl #(
  parameter int BITWIDTH   = 32,
  parameter int MODWIDTH   = 1,
  parameter int POST_COUNT = 16
) (
  input  logic                           comm_clock,
  input  logic                           comm_reset,
  input  logic                           arm,
  input  logic                           force_dump,
  input  logic                           trig_enable,
  input  logic [BITWIDTH-1:0]            trig_addr,
  input  logic [BITWIDTH-1:0]            trig_mask,
  input  logic                           bus_valid,
  input  logic [2*BITWIDTH+MODWIDTH-1:0] bus_data,
  output logic                           fifo_wr,
  output logic [2*BITWIDTH+MODWIDTH-1:0] fifo_wr_data,
  output logic                           fifo_rd,
  output logic                           fifo_flush,
  input  logic                           fifo_full,
  input  logic                           fifo_empty,
  input  logic                           dump_in_ready,
  output logic                           dump_start,
  input  logic                           dump_end,
  output logic [2:0]                     state,
  output logic [15:0]                    missed
);

  localparam int RW = 2*BITWIDTH + MODWIDTH;
  localparam int CW = (POST_COUNT < 1) ? 1 : $clog2(POST_COUNT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(POST_COUNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRETRIG  = 3'd1,
    S_POSTTRIG = 3'd2,
    S_DUMP_REQ = 3'd3,
    S_DUMPING  = 3'd4
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [CW-1:0]   post_cnt;
  logic            wr_q;
  logic            ring_rd_q;
  logic            flush_q;
  logic [RW-1:0]   wr_data_q;
  logic [15:0]     missed_q;

  logic            match;
  logic            has_data;
  logic            do_wr;
  logic            do_ring_rd;
  logic            do_flush;
  logic            do_miss;
  logic            cnt_load;
  logic            cnt_dec;

  assign match = trig_enable &&
                 (((bus_data[2*BITWIDTH-1:BITWIDTH] ^ trig_addr) & trig_mask) == '0);

  // A write landing this cycle counts as data; a flush in progress empties the FIFO at this edge.
  assign has_data = wr_q || (!fifo_empty && !flush_q);

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    do_wr      = 1'b0;
    do_ring_rd = 1'b0;
    do_flush   = 1'b0;
    do_miss    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (arm) begin
          do_flush  = 1'b1;
          nxt_state = S_PRETRIG;
        end
      end
      S_PRETRIG: begin
        if (arm) begin
          do_flush  = 1'b1;
          nxt_state = S_PRETRIG;
        end else if (bus_valid) begin
          do_wr      = 1'b1;
          do_ring_rd = fifo_full;
          if (match) begin
            if (POST_COUNT == 0) begin
              nxt_state = S_DUMP_REQ;
            end else begin
              cnt_load  = 1'b1;
              nxt_state = S_POSTTRIG;
            end
          end
          if (force_dump) begin
            nxt_state = S_DUMP_REQ;
          end
        end else if (force_dump) begin
          nxt_state = has_data ? S_DUMP_REQ : S_IDLE;
        end
      end
      S_POSTTRIG: begin
        if (arm) begin
          do_flush  = 1'b1;
          nxt_state = S_PRETRIG;
        end else if (bus_valid) begin
          // Post-trigger data is never overwritten: a full FIFO ends the capture.
          if (fifo_full) begin
            do_miss   = 1'b1;
            nxt_state = S_DUMP_REQ;
          end else begin
            do_wr   = 1'b1;
            cnt_dec = 1'b1;
            if ((post_cnt == CNT_ONE) || force_dump) begin
              nxt_state = S_DUMP_REQ;
            end
          end
        end else if (force_dump) begin
          nxt_state = S_DUMP_REQ;
        end
      end
      S_DUMP_REQ: begin
        do_miss   = bus_valid;
        nxt_state = S_DUMPING;
      end
      S_DUMPING: begin
        do_miss = bus_valid;
        if (dump_end) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      wr_q      <= 1'b0;
      ring_rd_q <= 1'b0;
      flush_q   <= 1'b0;
      wr_data_q <= '0;
      missed_q  <= 16'd0;
      post_cnt  <= '0;
    end else begin
      wr_q      <= do_wr;
      ring_rd_q <= do_ring_rd;
      flush_q   <= do_flush;
      if (do_wr) begin
        wr_data_q <= bus_data;
      end
      if (do_flush) begin
        missed_q <= 16'd0;
      end else if (do_miss && (missed_q != 16'hFFFF)) begin
        missed_q <= missed_q + 16'd1;
      end
      if (cnt_load) begin
        post_cnt <= CNT_INIT;
      end else if (cnt_dec) begin
        post_cnt <= post_cnt - CNT_ONE;
      end
    end
  end

  assign fifo_wr      = wr_q;
  assign fifo_wr_data = wr_data_q;
  assign fifo_flush   = flush_q;
  assign dump_start   = (cur_state == S_DUMP_REQ);
  // While dumping the dumper owns the read port directly, without a register stage.
  assign fifo_rd      = ring_rd_q || ((cur_state == S_DUMPING) && dump_in_ready);
  assign state        = cur_state;
  assign missed       = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_computie_bus_capture_ctrl.sv
// Bench for computie_bus_capture_ctrl: a 4-deep FIFO model plus a write scoreboard and trigger table.
`default_nettype none

module tb_computie_bus_capture_ctrl;

  localparam int BW    = 32;
  localparam int RW    = 2*BW + 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm, force_dump, trig_enable, bus_valid;
  logic [BW-1:0] trig_addr, trig_mask;
  logic [RW-1:0] bus_data;
  logic          fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
  logic [RW-1:0] fifo_wr_data;
  logic          dump_in_ready, dump_start, dump_end;
  logic [2:0]    state;
  logic [15:0]   missed;

  always #5 clk = ~clk;

  computie_bus_capture_ctrl #(.BITWIDTH(BW), .MODWIDTH(1), .POST_COUNT(2)) dut (
    .comm_clock(clk), .comm_reset(rst), .arm(arm), .force_dump(force_dump),
    .trig_enable(trig_enable), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .bus_valid(bus_valid), .bus_data(bus_data), .fifo_wr(fifo_wr),
    .fifo_wr_data(fifo_wr_data), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .dump_in_ready(dump_in_ready),
    .dump_start(dump_start), .dump_end(dump_end), .state(state), .missed(missed)
  );

  // FIFO model: accepts simultaneous read and write when full.
  logic [RW-1:0] fmem [0:DEPTH-1];
  int            fcnt, wp, rp;
  logic          rd_eff, wr_eff;
  assign rd_eff     = fifo_rd && (fcnt != 0);
  assign wr_eff     = fifo_wr && ((fcnt != DEPTH) || rd_eff);
  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst || fifo_flush) begin
      fcnt <= 0;
      wp   <= 0;
      rp   <= 0;
    end else begin
      if (wr_eff) begin
        fmem[wp] <= fifo_wr_data;
        wp       <= (wp + 1) % DEPTH;
      end
      if (rd_eff) rp <= (rp + 1) % DEPTH;
      fcnt <= fcnt + (wr_eff ? 1 : 0) - (rd_eff ? 1 : 0);
    end
  end

  typedef struct {
    logic [BW-1:0] mask;
    logic [BW-1:0] taddr;
    logic [BW-1:0] addr;
    logic          en;
    logic [2:0]    exp_state;
  } vec_t;

  vec_t          vecs [6];
  logic [RW-1:0] exp_q [$];
  int            trace [$];
  int            total = 0;
  int            bad = 0;
  int            cyc_n = 0;
  int            wr_seen = 0;
  int            ring_rw = 0;
  int            ds_cnt = 0;
  int            ds_cyc = 0;
  int            last_wr_cyc = 0;
  int            prev_state = 0;
  logic [RW-1:0] last_rec;
  logic [RW-1:0] saved_rec;
  logic [RW-1:0] exp_rec;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    cyc_n++;
    if (fifo_wr) begin
      wr_seen++;
      last_wr_cyc = cyc_n;
      if (fifo_rd) ring_rw++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1'b1, 1'b0);
      end else begin
        exp_rec = exp_q.pop_front();
        chk("wr_data", fifo_wr_data, exp_rec);
      end
    end
    if (dump_start) begin
      ds_cnt++;
      ds_cyc = cyc_n;
      chk("dump_start_state", state, 3'd3);
    end
    if (state == 3'd4) begin
      chk("dump_rd_mirror", fifo_rd, dump_in_ready);
    end
    if (int'(state) != prev_state) begin
      trace.push_back(int'(state));
      prev_state = int'(state);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    arm        = 1'b0;
    force_dump = 1'b0;
    bus_valid  = 1'b0;
  endtask

  task automatic bus(input logic [BW-1:0] addr, input logic store);
    last_rec  = {1'($urandom_range(0, 1)), addr, BW'($urandom)};
    bus_data  = last_rec;
    bus_valid = 1'b1;
    if (store) exp_q.push_back(last_rec);
    cyc();
    cyc();
  endtask

  initial begin
    vecs[0] = '{32'hFFFFFF00, 32'h12345600, 32'h123456AB, 1'b1, 3'd2};
    vecs[1] = '{32'hFFFFFF00, 32'h12345600, 32'h12345700, 1'b1, 3'd1};
    vecs[2] = '{32'hFFFFFFFF, 32'h00001000, 32'h00001000, 1'b0, 3'd1};
    vecs[3] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b1, 3'd2};
    vecs[4] = '{32'hFFFFFFFF, 32'h00001000, 32'h00001001, 1'b1, 3'd1};
    vecs[5] = '{32'h0000F000, 32'h0000A000, 32'hFFFFAFFF, 1'b1, 3'd2};

    rst = 1'b1; arm = 0; force_dump = 0; trig_enable = 0; bus_valid = 0;
    trig_addr = '0; trig_mask = '0; bus_data = '0; dump_in_ready = 0; dump_end = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_flush", fifo_flush, 1'b0);
    chk("rst_dstart", dump_start, 1'b0);
    chk("rst_wdata", fifo_wr_data, '0);
    chk("rst_missed", missed, 16'd0);
    rst = 1'b0;
    cyc();

    // Trigger match table; each vector re-arms, including from POSTTRIG.
    for (int i = 0; i < 6; i++) begin
      trig_mask = vecs[i].mask; trig_addr = vecs[i].taddr; trig_enable = vecs[i].en;
      arm = 1'b1;
      cyc();
      chk("arm_flush", fifo_flush, 1'b1);
      bus(vecs[i].addr, 1'b1);
      chk($sformatf("trig_vec%0d", i), state, vecs[i].exp_state);
    end

    // Main capture: pre-trigger record, trigger, two post records, then dump.
    trig_enable = 1; trig_addr = 32'h00001000; trig_mask = 32'hFFFFFFFF;
    trace.delete();
    wr_seen = 0;
    ds_cnt  = 0;
    arm = 1'b1;
    cyc();
    bus(32'h00000004, 1'b1);
    bus(32'h00001000, 1'b1);
    bus(32'h00000008, 1'b1);
    bus(32'h0000000C, 1'b1);
    chk("main_writes", wr_seen, 4);
    chk("main_dstart", ds_cnt, 1);
    chk("dstart_after_wr", ds_cyc >= last_wr_cyc, 1'b1);
    chk("main_dumping", state, 3'd4);
    for (int i = 0; i < 3; i++) begin
      bus_data = {1'b1, 32'hCAFE0000 + BW'(i), 32'h0};
      bus_valid = 1'b1; dump_in_ready = 1'b1;
      cyc();
      dump_in_ready = 1'b0;
      cyc();
    end
    chk("dump_missed", missed, 16'd3);
    dump_end = 1'b1;
    repeat (3) cyc();
    dump_end = 1'b0;
    cyc();
    chk("dump_idle", state, 3'd0);
    chk("dstart_once", ds_cnt, 1);
    chk("trace_len", trace.size(), 5);
    if (trace.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("trace%0d", i), trace[i], (i + 1) % 5);
    end

    // Ring in PRETRIG: fifth record into a full FIFO pops the oldest.
    trig_enable = 0;
    ring_rw = 0;
    arm = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      bus(32'h00000100 + BW'(i), 1'b1);
      if (i == 1) saved_rec = last_rec;
    end
    chk("ring_rw", ring_rw, 1);
    chk("ring_count", fcnt, DEPTH);
    chk("ring_oldest", fmem[rp], saved_rec);

    // Trigger into a full FIFO, then a post record that cannot be stored.
    trig_enable = 1; trig_addr = 32'h00002000;
    bus(32'h00002000, 1'b1);
    chk("full_trig_state", state, 3'd2);
    chk("full_trig_ring", ring_rw, 2);
    bus(32'h00003000, 1'b0);
    chk("post_full_missed", missed, 16'd1);
    chk("post_full_state", state, 3'd4);
    chk("post_full_dstart", ds_cnt, 2);
    dump_end = 1'b1;
    cyc();
    dump_end = 1'b0;
    chk("post_full_idle", state, 3'd0);

    // force_dump right after arm: the flush leaves nothing to dump.
    arm = 1'b1;
    cyc();
    force_dump = 1'b1;
    cyc();
    cyc();
    chk("fd_empty_state", state, 3'd0);
    chk("fd_empty_nodump", ds_cnt, 2);

    // Async reset in the middle of a dump.
    arm = 1'b1;
    cyc();
    bus(32'h00000040, 1'b1);
    force_dump = 1'b1;
    cyc();
    cyc();
    chk("fd_dumping", state, 3'd4);
    bus_valid = 1'b1;
    cyc();
    chk("pre_rst_missed", missed, 16'd1);
    dump_in_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 3'd0);
    chk("arst_rd", fifo_rd, 1'b0);
    chk("arst_wr", fifo_wr, 1'b0);
    chk("arst_dstart", dump_start, 1'b0);
    chk("arst_missed", missed, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dump_in_ready = 1'b0;
    cyc();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
